// File: rtl/add_sub_seq_pkg.sv
// rtl/add_sub_seq_pkg.sv - shared definitions for the sliced adder/subtractor
// Purpose: FSM state encoding, operation-select constant and an index-width helper.
package add_sub_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Value of the sub input that selects A - B.
  localparam logic OP_SUB = 1'b1;

  // Slice index needs at least one bit even for a single-slice build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_seq_if.sv
// rtl/add_sub_seq_if.sv - operand/result bus for the sliced adder/subtractor
// Purpose: groups the start/busy/done handshake, operands and result flags.
// Ports (signals): start, sub, cin, A, B (requester -> unit);
//                  busy, done, result, cout, ovf, zero, neg (unit -> requester).
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output start, sub, cin, A, B,
    input  busy, done, result, cout, ovf, zero, neg
  );

  modport slave (
    input  start, sub, cin, A, B,
    output busy, done, result, cout, ovf, zero, neg
  );

endinterface

// File: rtl/add_sub_seq_add_slice.sv
// rtl/add_sub_seq_add_slice.sv - combinational SLICE-bit ripple adder
// Purpose: one slice of the multi-cycle add; carry ripples bit by bit.
// Ports: a, b (slice operands), ci (carry in), s (slice sum), co (carry out).
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_sub_seq.sv
// rtl/add_sub_seq.sv - multi-cycle adder/subtractor, SLICE bits per clock
// Purpose: computes A + B + cin or A - B over WIDTH/SLICE clocks, LSB slice first,
//          and reports result with carry, signed overflow, zero and negative flags.
// Ports: clock (rising edge), clear (synchronous active-high reset),
//        bus (slave side of add_sub_seq_if: start/sub/cin/A/B in,
//        busy/done/result/cout/ovf/zero/neg out).
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic         clock,
  input  logic         clear,
  add_sub_seq_if.slave bus
);

  // Guarded so that a bad parameter set still elaborates far enough to report.
  localparam int SL    = (SLICE > 0) ? SLICE : 1;
  localparam int N     = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int IDX_W = idx_width(N);

  if ((SLICE == 0) || ((WIDTH % SL) != 0)) begin : g_bad_params
    $error("add_sub_seq: WIDTH (%0d) must be a nonzero multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [SL-1:0]    a_sl;
  logic [SL-1:0]    b_sl;
  logic [SL-1:0]    s_sl;
  logic             co_sl;
  logic             last_slice;

  // One adder shared by all slices; the index register picks the operand slice.
  assign a_sl = a_q[idx_q*SL +: SL];
  assign b_sl = b_q[idx_q*SL +: SL];

  add_slice #(.SLICE(SL)) u_add_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry_q),
    .s  (s_sl),
    .co (co_sl)
  );

  // Accumulator with the current slice merged in, so the completion edge can
  // publish the full result without waiting another cycle.
  always_comb begin
    acc_d                  = acc_q;
    acc_d[idx_q*SL +: SL]  = s_sl;
  end

  assign last_slice = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Also reached in the done cycle, which gives back-to-back issue.
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= (bus.sub == OP_SUB) ? ~bus.B : bus.B;
            carry_q <= (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= co_sl;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            result_q <= acc_d;
            cout_q   <= co_sl;
            // Signed overflow: operands agree in sign but the sum does not.
            ovf_q    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_q   <= (acc_d == '0);
            neg_q    <= acc_d[WIDTH-1];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb/tb_add_sub_seq.sv - self-checking bench for add_sub_seq
module tb_add_sub_seq;

  localparam int N = 4;

  typedef struct {
    string       name;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } vec_t;

  logic clock;
  logic clear;

  add_sub_seq_if #(.WIDTH(32)) bus ();
  add_sub_seq_if #(.WIDTH(32)) bus2 ();

  add_sub_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  add_sub_seq #(.WIDTH(32), .SLICE(32)) dut2 (
    .clock (clock),
    .clear (clear),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  vec_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse is matched against the oldest issued op.
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      vec_t e;
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_flags"}, {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg},
              {28'd0, e.cout, e.ovf, e.zero, e.neg});
      end
    end
  end

  task automatic drive_start(input vec_t v);
    bus.start = 1'b1;
    bus.sub   = v.sub;
    bus.cin   = v.cin;
    bus.A     = v.a;
    bus.B     = v.b;
    sb.push_back(v);
  endtask

  // Drop start just after the accepting edge and scramble the inputs, which
  // must no longer matter.
  task automatic release_start();
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.A     = ~bus.A;
    bus.B     = 32'hA5A5_5A5A;
    bus.sub   = ~bus.sub;
    bus.cin   = ~bus.cin;
  endtask

  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
    end
  endtask

  function automatic vec_t mk(input string name, input logic sub, input logic cin,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic cout, input logic ovf,
                              input logic zero, input logic neg);
    vec_t v;
    v.name = name; v.sub = sub; v.cin = cin; v.a = a; v.b = b;
    v.res = res; v.cout = cout; v.ovf = ovf; v.zero = zero; v.neg = neg;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   bc;
    bit   seen;
    int   dc;
    vec_t v;

    vecs[0] = mk("add_5_3",      0, 0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 0, 0, 0, 0);
    vecs[1] = mk("add_wrap",     0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0);
    vecs[2] = mk("add_ovf",      0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1);
    vecs[3] = mk("sub_5_7",      1, 0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0, 1);
    vecs[4] = mk("sub_ovf",      1, 1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0, 0);
    vecs[5] = mk("add_cin_slc",  0, 1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0101, 0, 0, 0, 0);
    vecs[6] = mk("sub_equal",    1, 0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1, 0, 1, 0);
    vecs[7] = mk("add_mixed",    0, 0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 0, 0, 0, 0);

    bus.start = 0; bus.sub = 0; bus.cin = 0; bus.A = '0; bus.B = '0;
    bus2.start = 0; bus2.sub = 0; bus2.cin = 0; bus2.A = '0; bus2.B = '0;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 0);
    clear = 1'b0;

    // Table-driven single operations.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive_start(vecs[i]);
      release_start();
      wait_done(bc, seen);
      check({vecs[i].name, "_done_seen"}, seen, 1);
      check({vecs[i].name, "_busy_cycles"}, bc, N);
      @(negedge clock);
      check({vecs[i].name, "_done_one_cycle"}, bus.done, 0);
    end

    // Start while busy is ignored.
    dc = done_count;
    @(negedge clock);
    drive_start(mk("busy_ignore", 0, 0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0));
    release_start();
    @(negedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.A = 32'd9; bus.B = 32'd9; bus.sub = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done(bc, seen);
    check("busy_ignore_done_seen", seen, 1);
    repeat (6) @(negedge clock);
    check("busy_ignore_done_count", done_count - dc, 1);

    // Clear mid-operation aborts with no done pulse.
    @(negedge clock);
    drive_start(mk("aborted", 0, 0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0));
    release_start();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    sb.delete();
    dc = done_count;
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 0);
    repeat (6) @(negedge clock);
    check("abort_no_done", done_count - dc, 0);
    @(negedge clock);
    drive_start(mk("after_abort", 0, 0, 32'd2, 32'd2, 32'd4, 0, 0, 0, 0));
    release_start();
    wait_done(bc, seen);
    check("after_abort_done_seen", seen, 1);
    check("after_abort_busy_cycles", bc, N);

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clock);
    drive_start(mk("b2b_first", 0, 0, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 0, 0, 0, 0));
    release_start();
    wait_done(bc, seen);
    check("b2b_first_done_seen", seen, 1);
    v = mk("b2b_second", 1, 0, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 0, 0, 0, 1);
    drive_start(v);
    @(posedge clock);
    #1;
    check("b2b_busy_rises", bus.busy, 1);
    check("b2b_done_falls", bus.done, 0);
    bus.start = 1'b0;
    bus.A = 32'hDEAD_BEEF;
    wait_done(bc, seen);
    check("b2b_second_done_seen", seen, 1);
    check("b2b_second_busy_cycles", bc, N);
    repeat (2) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);

    // Single-cycle build: done one edge after start.
    @(negedge clock);
    bus2.start = 1'b1; bus2.sub = 1'b0; bus2.cin = 1'b0;
    bus2.A = 32'h0000_0010; bus2.B = 32'h0000_0020;
    @(posedge clock);
    #1;
    bus2.start = 1'b0; bus2.A = '1; bus2.B = '1;
    @(negedge clock);
    check("s32_busy_after_start", bus2.busy, 1);
    check("s32_no_early_done", bus2.done, 0);
    @(negedge clock);
    check("s32_done", bus2.done, 1);
    check("s32_result", bus2.result, 32'h0000_0030);
    check("s32_busy_clear", bus2.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
